split_target: RTL and testbench
===============================

# split_target

Bus-side memory target that completes the transactions issued by the bus initiator: it accepts address, write-data and direction from the bus, commits writes into a small register-file memory and returns read data with an acknowledge. Reads take a programmable latency. With `SPLIT_EN` set, the target releases the bus during that latency using a split acknowledge, then requests the bus back to deliver the data. It sits behind the bus arbiter/mux on the target port.

## Interface

Parameters:

- `MEM_ADDR_BITS`, 4: depth is 2^`MEM_ADDR_BITS` bytes. Only `target_addr_in[MEM_ADDR_BITS-1:0]` is decoded; upper bits alias.
- `READ_LATENCY`, 4: number of cycles spent in `READ_WAIT`; must be ≥1.
- `SPLIT_EN`, 1: 1 selects split reads, 0 selects in-place reads.
- `MEM_INIT_DATA`, 8'h00: reset value of location i is `MEM_INIT_DATA + i` (8-bit wrap).

Ports:

- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `target_addr_in` in 16: transaction address.
- `target_addr_in_valid` in 1: address strobe; `target_rw` is sampled with it.
- `target_data_in` in 8: write data.
- `target_data_in_valid` in 1: write-data strobe.
- `target_rw` in 1: 1 = write, 0 = read.
- `target_split_grant` in 1: arbiter re-grant after a split.
- `target_ready` out 1: high only in `IDLE`.
- `target_ack` out 1: one-cycle transaction-complete pulse.
- `target_split_ack` out 1: one-cycle pulse meaning the bus is released.
- `target_split_req` out 1: level request to resume a split read.
- `target_data_out` out 8: read data; holds its last value between responses.
- `target_data_out_valid` out 1: one-cycle pulse, always coincident with `target_ack` on reads.

## Operation

- All outputs are registered. Reset values: `target_ready`=1; `target_data_out`=8'h00; all other outputs 0. Reset also clears the state to `IDLE`, clears the capture flags and reinitialises the memory.
- States are `IDLE`, `WRITE_ACK`, `READ_WAIT`, `SPLIT_REQ` and `RESPOND`.
- `IDLE`:
  - `target_addr_in_valid` latches the address and rw, and sets `addr_got`.
  - `target_data_in_valid` latches the data and sets `data_got`.
  - The two strobes may arrive in the same cycle or in either order; completion is evaluated against the flags including the current cycle's strobes.
  - Write (`addr_got` with rw=1, and `data_got`): memory is written on that edge, next state `WRITE_ACK`.
  - Read (`addr_got` with rw=0): load the latency counter with `READ_LATENCY`, next state `READ_WAIT`. Any latched data is discarded.
- `WRITE_ACK`: `target_ack`=1 for one cycle, then `IDLE`.
- `READ_WAIT`:
  - In the first cycle, `target_split_ack`=1 if `SPLIT_EN`.
  - The counter decrements each cycle. When it expires, the memory word is registered into `target_data_out`. Next state is `RESPOND` if `SPLIT_EN`=0, otherwise `SPLIT_REQ`.
- `SPLIT_REQ`: `target_split_req`=1 until `target_split_grant` is sampled high, then `RESPOND`. Grant outside `SPLIT_REQ` is ignored.
- `RESPOND`: `target_ack`=1 and `target_data_out_valid`=1 for one cycle, then `IDLE`.
- On return to `IDLE`, `addr_got` and `data_got` are cleared. Strobes received outside `IDLE` are ignored.

## Timing

- Address and data strobes sampled at edge T:
  - Write: memory is updated at T; `target_ack` is high in cycle T+1.
  - Non-split read: `target_ack` and `target_data_out_valid` are high in cycle T+1+`READ_LATENCY`.
  - Split read: `target_split_ack` is high in cycle T+1. `target_split_req` rises at T+1+`READ_LATENCY`. With grant sampled at edge G, the response is in cycle G+1.
- A read of an address written by the immediately preceding transaction returns the new data (memory is already updated before `WRITE_ACK`).
- `target_ready` is low from T+1 until the cycle after the `target_ack` pulse.
- Reset asserted mid-transaction aborts it immediately: no `target_ack` and no split request follow deassertion.

## Test plan

- **Write:** addr 0x0012 and data 0xAB strobed together with rw=1 at T. Required: `target_ack` pulses at T+1, `target_ready` returns high at T+2.
- **Non-split read** (`SPLIT_EN`=0, `READ_LATENCY`=4): read 0x0012. Required: ack and data valid at T+5 with `target_data_out`=0xAB. A read of 0x0032 (aliases to the same location) also returns 0xAB.
- **Split read** (`SPLIT_EN`=1): read 0x0004 after reset with `MEM_INIT_DATA`=0xAA. Required: `target_split_ack` at T+1, `target_split_req` from T+5. Grant delayed 3 cycles is followed by a single ack/valid pulse with data 0xAE, then `target_split_req` low.
- **Data before address:** data 0x5C strobed at T, addr 0x0003 with rw=1 at T+2. Required: write committed, ack at T+3, readback 0x5C.
- **Ignored strobes:** a data strobe accompanying a read, and strobes during `READ_WAIT`. Required: memory unchanged and exactly one ack.
- **Mid-read reset:** `rst_n` pulsed during `READ_WAIT`. Required: all outputs at reset values, memory at init values, no ack after release.

Source files
------------

// File: rtl/split_target.sv
// Bus-side memory target: byte register-file behind the bus mux, with optional split reads
// that release the bus during the read latency and re-request it to deliver the data.
module split_target #(
    parameter int          MEM_ADDR_BITS = 4,
    parameter int          READ_LATENCY  = 4,
    parameter bit          SPLIT_EN      = 1'b1,
    parameter logic [7:0]  MEM_INIT_DATA = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    input  logic        target_rw,
    input  logic        target_split_grant,
    output logic        target_ready,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        target_split_req,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE_ACK = 3'd1,
        READ_WAIT = 3'd2,
        SPLIT_REQ = 3'd3,
        RESPOND   = 3'd4
    } state_t;

    state_t                   state_q;
    logic [7:0]               mem_q [DEPTH];
    logic [MEM_ADDR_BITS-1:0] addr_q, addr_d;
    logic                     rw_q, rw_d;
    logic [7:0]               data_q, data_d;
    logic                     addr_got_q, addr_got_d;
    logic                     data_got_q, data_got_d;
    logic [CNT_W-1:0]         cnt_q;

    logic       ready_q, ack_q, split_ack_q, split_req_q, data_out_valid_q;
    logic [7:0] data_out_q;

    // Upper address bits alias onto the decoded range.
    logic unused_addr_bits;
    assign unused_addr_bits = ^target_addr_in[15:MEM_ADDR_BITS];

    // Handshake: strobes are only accepted while target_ready is high (IDLE); each
    // transaction completes with exactly one target_ack pulse, after which ready returns.
    always_comb begin
        addr_got_d = addr_got_q | target_addr_in_valid;
        addr_d     = target_addr_in_valid ? target_addr_in[MEM_ADDR_BITS-1:0] : addr_q;
        rw_d       = target_addr_in_valid ? target_rw : rw_q;
        data_got_d = data_got_q | target_data_in_valid;
        data_d     = target_data_in_valid ? target_data_in : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            addr_q           <= '0;
            rw_q             <= 1'b0;
            data_q           <= 8'h00;
            addr_got_q       <= 1'b0;
            data_got_q       <= 1'b0;
            cnt_q            <= '0;
            ready_q          <= 1'b1;
            ack_q            <= 1'b0;
            split_ack_q      <= 1'b0;
            split_req_q      <= 1'b0;
            data_out_q       <= 8'h00;
            data_out_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= MEM_INIT_DATA + 8'(i);
            end
        end else begin
            ack_q            <= 1'b0;
            split_ack_q      <= 1'b0;
            data_out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    addr_q     <= addr_d;
                    rw_q       <= rw_d;
                    data_q     <= data_d;
                    addr_got_q <= addr_got_d;
                    data_got_q <= data_got_d;
                    // A read wins over any data already captured; that data is dropped.
                    if (addr_got_d && !rw_d) begin
                        cnt_q       <= CNT_LOAD;
                        split_ack_q <= SPLIT_EN;
                        ready_q     <= 1'b0;
                        state_q     <= READ_WAIT;
                    end else if (addr_got_d && data_got_d) begin
                        mem_q[addr_d] <= data_d;
                        ack_q         <= 1'b1;
                        ready_q       <= 1'b0;
                        state_q       <= WRITE_ACK;
                    end
                end
                WRITE_ACK: begin
                    addr_got_q <= 1'b0;
                    data_got_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                READ_WAIT: begin
                    if (cnt_q <= CNT_ONE) begin
                        data_out_q <= mem_q[addr_q];
                        if (SPLIT_EN) begin
                            split_req_q <= 1'b1;
                            state_q     <= SPLIT_REQ;
                        end else begin
                            ack_q            <= 1'b1;
                            data_out_valid_q <= 1'b1;
                            state_q          <= RESPOND;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                SPLIT_REQ: begin
                    if (target_split_grant) begin
                        split_req_q      <= 1'b0;
                        ack_q            <= 1'b1;
                        data_out_valid_q <= 1'b1;
                        state_q          <= RESPOND;
                    end
                end
                RESPOND: begin
                    addr_got_q <= 1'b0;
                    data_got_q <= 1'b0;
                    ready_q    <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    split_req_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign target_ready          = ready_q;
    assign target_ack            = ack_q;
    assign target_split_ack      = split_ack_q;
    assign target_split_req      = split_req_q;
    assign target_data_out       = data_out_q;
    assign target_data_out_valid = data_out_valid_q;

endmodule

// File: tb/tb_split_target.sv
// Directed bench for split_target: one non-split and one split instance driven in lockstep.
module tb_split_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr_in;
    logic        addr_v, data_v, rw, grant;
    logic [7:0]  data_in;

    logic       ready_ns, ack_ns, sack_ns, sreq_ns, dval_ns;
    logic [7:0] dout_ns;
    logic       ready_sp, ack_sp, sack_sp, sreq_sp, dval_sp;
    logic [7:0] dout_sp;

    int n_asserts = 0;
    int n_fail    = 0;
    int ack_cnt_ns = 0;
    int ack_cnt_sp = 0;

    always #5 clk = ~clk;

    split_target #(
        .MEM_ADDR_BITS(4), .READ_LATENCY(4), .SPLIT_EN(1'b0), .MEM_INIT_DATA(8'h00)
    ) dut_ns (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in), .target_addr_in_valid(addr_v),
        .target_data_in(data_in), .target_data_in_valid(data_v),
        .target_rw(rw), .target_split_grant(grant),
        .target_ready(ready_ns), .target_ack(ack_ns),
        .target_split_ack(sack_ns), .target_split_req(sreq_ns),
        .target_data_out(dout_ns), .target_data_out_valid(dval_ns)
    );

    split_target #(
        .MEM_ADDR_BITS(4), .READ_LATENCY(4), .SPLIT_EN(1'b1), .MEM_INIT_DATA(8'hAA)
    ) dut_sp (
        .clk(clk), .rst_n(rst_n),
        .target_addr_in(addr_in), .target_addr_in_valid(addr_v),
        .target_data_in(data_in), .target_data_in_valid(data_v),
        .target_rw(rw), .target_split_grant(grant),
        .target_ready(ready_sp), .target_ack(ack_sp),
        .target_split_ack(sack_sp), .target_split_req(sreq_sp),
        .target_data_out(dout_sp), .target_data_out_valid(dval_sp)
    );

    always @(negedge clk) begin
        if (ack_ns) ack_cnt_ns++;
        if (ack_sp) ack_cnt_sp++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr_v = 1'b0;
        data_v = 1'b0;
        rw     = 1'b0;
        grant  = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready_ns"}, 32'(ready_ns), 1);
        chk({tag, "_ack_ns"},   32'(ack_ns),   0);
        chk({tag, "_sack_ns"},  32'(sack_ns),  0);
        chk({tag, "_sreq_ns"},  32'(sreq_ns),  0);
        chk({tag, "_dout_ns"},  32'(dout_ns),  0);
        chk({tag, "_dval_ns"},  32'(dval_ns),  0);
        chk({tag, "_ready_sp"}, 32'(ready_sp), 1);
        chk({tag, "_ack_sp"},   32'(ack_sp),   0);
        chk({tag, "_sack_sp"},  32'(sack_sp),  0);
        chk({tag, "_sreq_sp"},  32'(sreq_sp),  0);
        chk({tag, "_dout_sp"},  32'(dout_sp),  0);
        chk({tag, "_dval_sp"},  32'(dval_sp),  0);
    endtask

    // Read strobed at edge T; the split instance is granted at edge T+8.
    task automatic do_read(input logic [15:0] a, input logic [7:0] e_ns, input logic [7:0] e_sp,
                           input bit inject);
        int c_ns, c_sp;
        c_ns = ack_cnt_ns;
        c_sp = ack_cnt_sp;
        addr_in = a; rw = 1'b0; addr_v = 1'b1;
        data_v = inject; data_in = 8'hFF;
        step();
        idle_inputs();
        chk("rd_ready_ns", 32'(ready_ns), 0);
        chk("rd_ready_sp", 32'(ready_sp), 0);
        chk("rd_sack_sp",  32'(sack_sp),  1);
        chk("rd_sack_ns",  32'(sack_ns),  0);
        if (inject) begin
            addr_in = a; rw = 1'b1; addr_v = 1'b1; data_v = 1'b1; data_in = 8'h11;
        end
        for (int i = 2; i <= 4; i++) begin
            step();
            idle_inputs();
            chk("rd_early_ack_ns", 32'(ack_ns),  0);
            chk("rd_early_req_sp", 32'(sreq_sp), 0);
            chk("rd_sack_once_sp", 32'(sack_sp), 0);
        end
        step();
        chk("rd_ack_ns",  32'(ack_ns),  1);
        chk("rd_dval_ns", 32'(dval_ns), 1);
        chk("rd_dout_ns", 32'(dout_ns), 32'(e_ns));
        chk("rd_req_rise_sp", 32'(sreq_sp), 1);
        chk("rd_no_ack_sp",   32'(ack_sp),  0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rd_req_hold_sp", 32'(sreq_sp), 1);
            chk("rd_wait_ack_sp", 32'(ack_sp),  0);
            if (i == 0) begin
                chk("rd_ack_end_ns", 32'(ack_ns),   0);
                chk("rd_ready_ns2",  32'(ready_ns), 1);
            end
        end
        grant = 1'b1;
        step();
        grant = 1'b0;
        chk("rd_ack_sp",     32'(ack_sp),  1);
        chk("rd_dval_sp",    32'(dval_sp), 1);
        chk("rd_dout_sp",    32'(dout_sp), 32'(e_sp));
        chk("rd_req_drop_sp", 32'(sreq_sp), 0);
        step();
        chk("rd_ack_end_sp", 32'(ack_sp),   0);
        chk("rd_ready_sp2",  32'(ready_sp), 1);
        chk("rd_req_low_sp", 32'(sreq_sp),  0);
        chk("rd_ack_count_ns", 32'(ack_cnt_ns - c_ns), 1);
        chk("rd_ack_count_sp", 32'(ack_cnt_sp - c_sp), 1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit data_first);
        if (data_first) begin
            data_in = d; data_v = 1'b1;
            step();
            idle_inputs();
            chk("wr_pending_ack_ns",   32'(ack_ns),   0);
            chk("wr_pending_ready_sp", 32'(ready_sp), 1);
            step();
            chk("wr_pending2_ack_sp",  32'(ack_sp),   0);
            chk("wr_pending2_ready_ns", 32'(ready_ns), 1);
            addr_in = a; rw = 1'b1; addr_v = 1'b1;
        end else begin
            addr_in = a; rw = 1'b1; addr_v = 1'b1;
            data_in = d; data_v = 1'b1;
        end
        step();
        idle_inputs();
        chk("wr_ack_ns",   32'(ack_ns),   1);
        chk("wr_ack_sp",   32'(ack_sp),   1);
        chk("wr_ready_ns", 32'(ready_ns), 0);
        chk("wr_ready_sp", 32'(ready_sp), 0);
        step();
        chk("wr_ack_end_ns", 32'(ack_ns),   0);
        chk("wr_ack_end_sp", 32'(ack_sp),   0);
        chk("wr_ready_back_ns", 32'(ready_ns), 1);
        chk("wr_ready_back_sp", 32'(ready_sp), 1);
    endtask

    initial begin
        idle_inputs();
        addr_in = 16'h0000;
        data_in = 8'h00;
        rst_n = 1'b0;
        step();
        step();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        do_read(16'h0004, 8'h04, 8'hAE, 1'b0);
        do_write(16'h0012, 8'hAB, 1'b0);
        do_read(16'h0012, 8'hAB, 8'hAB, 1'b0);
        do_read(16'h0032, 8'hAB, 8'hAB, 1'b0);
        do_write(16'h0003, 8'h5C, 1'b1);
        do_read(16'h0003, 8'h5C, 8'h5C, 1'b0);
        do_read(16'h0005, 8'h05, 8'hAF, 1'b1);
        do_read(16'h0005, 8'h05, 8'hAF, 1'b0);

        // Abort a read in flight and confirm the aborted transaction never completes.
        addr_in = 16'h0003; rw = 1'b0; addr_v = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_reset_ack_ns",  32'(ack_ns),  0);
            chk("post_reset_ack_sp",  32'(ack_sp),  0);
            chk("post_reset_sreq_sp", 32'(sreq_sp), 0);
        end
        do_read(16'h0003, 8'h03, 8'hAD, 1'b0);
        do_read(16'h0012, 8'h02, 8'hAC, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
